// File: rtl/instruction_fetch_stage.sv
// IF stage + IF/ID register of the five-stage MIPS core: req/ack fetch, one-entry skid buffer, delayed redirect.
// Build option IF_DELAY_SLOT_EN: when defined the delay-slot instruction reaches ID valid, otherwise it is squashed.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchTarget,
    output logic        imemRequest,
    output logic [31:0] imemAddress,
    input  logic        imemAcknowledge,
    input  logic [31:0] imemReadData,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_4,
    output logic        id_valid
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit SquashDelaySlot = 1'b0;
`else
    localparam bit SquashDelaySlot = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HELD
    } fetchState_t;

    fetchState_t state, nextState;

    logic [31:0] pc, nextPc, pcPlus4;
    logic        pendingRedirect, nextPendingRedirect;
    logic [31:0] pendingTarget, nextPendingTarget;
    logic [31:0] bufInstruction, nextBufInstruction;
    logic [31:0] bufPc4, nextBufPc4;
    logic        bufDelaySlot, nextBufDelaySlot;
    logic [31:0] nextIdInstruction, nextIdPc4;
    logic        nextIdValid;
    logic        redirectAccept;

    assign pcPlus4        = pc + 32'd4;
    assign redirectAccept = id_valid && shouldJumpOrBranch && !shouldStall;

    // Request and address come straight from registers so reset drops them asynchronously.
    assign imemRequest = (state == WAIT);
    assign imemAddress = pc;

    always_comb begin
        // NOTE: every next-value signal takes its hold value first, so no path through the case can infer a latch.
        nextState           = state;
        nextPc              = pc;
        nextPendingRedirect = pendingRedirect;
        nextPendingTarget   = pendingTarget;
        nextBufInstruction  = bufInstruction;
        nextBufPc4          = bufPc4;
        nextBufDelaySlot    = bufDelaySlot;
        nextIdInstruction   = id_instruction;
        nextIdPc4           = id_pc_4;
        nextIdValid         = id_valid;

        case (state)
            IDLE: begin
                nextState = WAIT;
            end

            WAIT: begin
                if (imemAcknowledge) begin
                    if (redirectAccept) begin
                        nextPc = jumpOrBranchTarget;
                    end else if (pendingRedirect) begin
                        nextPc = pendingTarget;
                    end else begin
                        nextPc = pcPlus4;
                    end
                    nextPendingRedirect = 1'b0;

                    if (shouldStall) begin
                        // A stalled redirect cannot be accepted, so only a pending one marks this as the delay slot.
                        nextBufInstruction = imemReadData;
                        nextBufPc4         = pcPlus4;
                        nextBufDelaySlot   = pendingRedirect;
                        nextState          = HELD;
                    end else begin
                        nextIdInstruction = imemReadData;
                        nextIdPc4         = pcPlus4;
                        nextIdValid       = 1'b1;
                        if (SquashDelaySlot && (redirectAccept || pendingRedirect)) begin
                            nextIdInstruction = '0;
                            nextIdValid       = 1'b0;
                        end
                    end
                end else begin
                    if (redirectAccept) begin
                        nextPendingRedirect = 1'b1;
                        nextPendingTarget   = jumpOrBranchTarget;
                    end
                    if (!shouldStall) begin
                        nextIdValid = 1'b0;
                    end
                end
            end

            HELD: begin
                if (!shouldStall) begin
                    // pc already advanced at capture time; only a redirect arriving with the release overrides it.
                    if (redirectAccept) begin
                        nextPc = jumpOrBranchTarget;
                    end
                    nextIdInstruction = bufInstruction;
                    nextIdPc4         = bufPc4;
                    nextIdValid       = 1'b1;
                    if (SquashDelaySlot && (redirectAccept || bufDelaySlot)) begin
                        nextIdInstruction = '0;
                        nextIdValid       = 1'b0;
                    end
                    nextBufDelaySlot = 1'b0;
                    nextState        = WAIT;
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            pendingRedirect <= 1'b0;
            pendingTarget   <= '0;
            bufInstruction  <= '0;
            bufPc4          <= '0;
            bufDelaySlot    <= 1'b0;
            id_instruction  <= '0;
            id_pc_4         <= '0;
            id_valid        <= 1'b0;
        end else begin
            state           <= nextState;
            pc              <= nextPc;
            pendingRedirect <= nextPendingRedirect;
            pendingTarget   <= nextPendingTarget;
            bufInstruction  <= nextBufInstruction;
            bufPc4          <= nextBufPc4;
            bufDelaySlot    <= nextBufDelaySlot;
            id_instruction  <= nextIdInstruction;
            id_pc_4         <= nextIdPc4;
            id_valid        <= nextIdValid;
        end
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

IF stage and IF/ID pipeline register of the five-stage MIPS core; sits directly upstream of the ID-stage control unit. Holds the PC and fetches over a req/ack instruction-memory port that may take several cycles. Feeds the instruction and PC+4 to ID. Honours the ID stall (WPCIR) and the ID-resolved jump/branch redirect, with the MIPS delay-slot rule.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- shouldStall  in  1  ID stall (WPCIR); holds the IF/ID register and PC
- shouldJumpOrBranch  in  1  ID redirect request (BRANCH)
- jumpOrBranchTarget  in  32  redirect target, valid with shouldJumpOrBranch
- imemRequest  out  1  fetch request
- imemAddress  out  32  fetch address, word aligned
- imemAcknowledge  in  1  fetch done; imemReadData valid this cycle
- imemReadData  in  32  fetched instruction
- id_instruction  out  32  IF/ID instruction
- id_pc_4  out  32  IF/ID PC+4
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- Reset values: pc=RESET_PC, state=IDLE, imemRequest=0, imemAddress=RESET_PC, id_instruction=0 (NOP), id_pc_4=0, id_valid=0, pendingRedirect=0, buffer empty.
- States:
  - IDLE: imemRequest=0. Always goes to WAIT next cycle.
  - WAIT: imemRequest=1 and imemAddress=pc. Both stay stable until an ack edge.
  - HELD: imemRequest=0. The fetched instruction sits in the one-entry skid buffer.
- WAIT, ack high, shouldStall low:
  - IF/ID loads imemReadData, pc+4, id_valid=1.
  - pc loads the next address. Stay in WAIT, so the next request goes out the following cycle.
- WAIT, ack high, shouldStall high:
  - The skid buffer captures the data and pc+4; go to HELD.
  - IF/ID is unchanged. pc is advanced as above.
- WAIT, ack low: IF/ID loads nothing and keeps its contents. If shouldStall is low, id_valid is cleared (bubble to ID).
- HELD, shouldStall low: buffer moves to IF/ID with id_valid=1; go to WAIT.
- HELD, shouldStall high: stay in HELD.
- shouldStall high always freezes id_instruction, id_pc_4 and id_valid.
- Redirect is accepted only when id_valid && shouldJumpOrBranch && !shouldStall. The fetch in flight or buffered is the delay slot.
- Next-address selection, in priority order:
  - redirect accepted in the same cycle as the delay-slot ack or release: jumpOrBranchTarget;
  - pendingRedirect set: pendingTarget, then pendingRedirect is cleared;
  - otherwise: pc+4.
- A redirect accepted before the delay slot completes sets pendingRedirect and latches pendingTarget.
- A second redirect while pendingRedirect is set cannot occur, because ID holds no new valid instruction. There is no requirement for it.
- Arithmetic: 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

## Timing
- The instruction acked at edge N is on id_instruction after edge N.
- With a zero-wait memory (ack in the request cycle), throughput is one instruction per cycle.
- A k-cycle memory gives one instruction per k cycles, with bubbles (id_valid=0) in between.
- The first request is asserted in the first cycle after reset_n rises plus one (the IDLE cycle).
- Redirect penalty: zero cycles with the delay slot executed. The target fetch starts in the cycle after the delay-slot ack or release.
- Reset asserted mid-fetch drops imemRequest immediately. The outstanding access is abandoned, and memory must ignore its late ack.

## Configuration
- IF_DELAY_SLOT_EN defined: the delay-slot instruction is delivered to ID with id_valid=1, as described above.
- IF_DELAY_SLOT_EN undefined: the delay slot is squashed.
  - When it completes, it loads IF/ID as id_instruction=0 with id_valid=0.
  - The pc and pendingRedirect handling is unchanged.

## Test plan
- Reset, RESET_PC=0, zero-wait memory -> requests at 0, 4, 8 on consecutive cycles. id_pc_4 goes 4, 8, 12 and id_valid stays 1 from the second post-reset cycle.
- Memory acks 3 cycles after each request -> one instruction every 3 cycles. id_valid=0 between them, and imemAddress stays stable while waiting.
- shouldStall high for 2 cycles while an ack arrives at 0x10 -> HELD, imemRequest=0, IF/ID frozen. After release, the 0x10 instruction appears with id_pc_4=0x14, with no loss or duplication.
- Branch at 0x20 redirects to 0x100 while the 0x24 fetch is still waiting -> 0x24 is delivered (id_valid=1 with the macro, id_valid=0 without it), then the next request is 0x100.
- Redirect in the same cycle as the delay-slot ack -> the following request is 0x100, never 0x28.
- reset_n pulsed low mid-WAIT -> all outputs are at reset values asynchronously, and the late ack is ignored.
